// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared constants and helpers for the 4-way round-robin mux arbiter.
package rr_mux4_arbiter_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction
endpackage

// File: rtl/mux4to1.sv
// Single-bit 4:1 multiplexer.
module mux4to1 (
  input  logic [3:0] i,
  input  logic [1:0] s,
  output logic       y
);
  assign y = i[s];
endmodule

// File: rtl/rr_pick4.sv
// Round-robin winner search: first set req bit scanning from ptr upward, wrapping.
module rr_pick4
  import rr_mux4_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  logic [2*N_REQ-1:0] dbl_s;
  logic [2*N_REQ-1:0] shifted_s;
  logic [N_REQ-1:0]   rot_s;
  logic [SEL_W-1:0]   off_s;

  // Rotate so the highest-priority requester sits at bit 0.
  assign dbl_s     = {req, req};
  assign shifted_s = dbl_s >> ptr;
  assign rot_s     = shifted_s[N_REQ-1:0];

  // Priority-encode the rotated vector into an offset from ptr.
  always_comb begin
    off_s = 2'd0;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
  end

  assign found = |req;
  assign idx   = ptr + off_s;
endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter driving a shared 4:1 data channel with bounded grant length.
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [4*DATA_W-1:0]   din,
  output logic [N_REQ-1:0]      gnt,
  output logic [SEL_W-1:0]      sel,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  busy
);
  logic [0:0]        state_r;
  logic [SEL_W-1:0]  ptr_r;
  logic [7:0]        hold_cnt_r;
  logic [N_REQ-1:0]  gnt_r;
  logic [SEL_W-1:0]  sel_r;
  logic [DATA_W-1:0] dout_r;
  logic              dout_valid_r;

  logic              found_s;
  logic [SEL_W-1:0]  idx_s;
  logic [SEL_W-1:0]  pick_ptr_s;
  logic              release_s;
  logic [DATA_W-1:0] mux_y_s;

  // While granted, the search must already use the post-release pointer (sel+1).
  assign pick_ptr_s = (state_r == ST_GRANT) ? (sel_r + 2'd1) : ptr_r;
  assign release_s  = ~req[sel_r] | (hold_cnt_r == 8'(MAX_HOLD));

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr_s),
    .found (found_s),
    .idx   (idx_s)
  );

  genvar j;
  generate
    for (j = 0; j < DATA_W; j++) begin : g_bit
      mux4to1 u_mux (
        .i ({din[3*DATA_W+j], din[2*DATA_W+j], din[DATA_W+j], din[j]}),
        .s (sel_r),
        .y (mux_y_s[j])
      );
    end
  endgenerate

  // Arbitration state, grant/select and registered output channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      ptr_r        <= 2'd0;
      hold_cnt_r   <= 8'd0;
      gnt_r        <= 4'b0000;
      sel_r        <= 2'd0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          dout_valid_r <= 1'b0;
          if (found_s) begin
            gnt_r      <= onehot4(idx_s);
            sel_r      <= idx_s;
            hold_cnt_r <= 8'd1;
            state_r    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          dout_r       <= mux_y_s;
          dout_valid_r <= req[sel_r];
          if (release_s) begin
            ptr_r <= sel_r + 2'd1;
            if (found_s) begin
              gnt_r      <= onehot4(idx_s);
              sel_r      <= idx_s;
              hold_cnt_r <= 8'd1;
            end else begin
              gnt_r      <= 4'b0000;
              hold_cnt_r <= 8'd0;
              state_r    <= ST_IDLE;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          gnt_r   <= 4'b0000;
        end
      endcase
    end
  end

  assign gnt        = gnt_r;
  assign sel        = sel_r;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign busy       = (state_r == ST_GRANT);
endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
Round-robin arbiter and sequencer for a shared 4:1 multiplexer channel. Four requesters each present a request and a DATA_W-bit word. The block grants one requester at a time, drives the mux select, and registers the selected word onto a single output channel with a valid flag. Grant length per requester is bounded by MAX_HOLD, so one requester cannot starve the others.

Parameters:
DATA_W, 1, width of each requester's data word and of dout.
MAX_HOLD, 4, maximum consecutive granted cycles per grant (legal range 1..255).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  4  request per requester; bit k = requester k
din  input  4*DATA_W  packed data; requester k occupies din[k*DATA_W +: DATA_W]
gnt  output  4  registered one-hot grant; all zero when idle
sel  output  2  registered mux select (index of current/last grantee)
dout  output  DATA_W  registered selected data
dout_valid  output  1  dout holds a valid beat from the granted requester
busy  output  1  high while in GRANT state

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). rst_n low immediately forces gnt=0000, sel=00, dout=0, dout_valid=0, busy=0, state=IDLE, ptr=0, hold_cnt=0. This applies mid-grant too; no beat completes.
- ptr = highest-priority index. Winner = first k with req[k]=1, scanning ptr, ptr+1, ... mod 4 (3 wraps to 0).
- States: IDLE, GRANT. busy = (state==GRANT).
- IDLE: if req != 0 at an edge, then at that edge gnt=onehot(winner), sel=winner, hold_cnt=1, state=GRANT. Otherwise remain idle; sel holds its last value and does not return to 0.
- GRANT, each edge: dout <= din[sel] and dout_valid <= req[sel]. Latency: a word on din during a granted cycle appears on dout after the next edge.
- Release condition in GRANT: req[sel]==0 OR hold_cnt==MAX_HOLD.
- On release, ptr <= sel+1 mod 4, and the winner is recomputed using the new ptr on the same edge.
  - If a winner exists: back-to-back grant with no idle cycle; gnt/sel switch and hold_cnt=1.
  - If the hold expired and the current grantee is the sole requester, it re-wins and hold_cnt resets to 1. There is no gap in dout_valid.
  - If no winner exists: gnt=0000, state=IDLE.
- No release: hold_cnt <= hold_cnt+1, and gnt/sel are unchanged.
- Requests are level-sensitive. A requester dropping req mid-grant loses the grant at the next edge; that cycle's dout_valid=0.
- New requests from non-granted requesters never preempt an active grant.
- hold_cnt width: 8 bits (covers MAX_HOLD≤255). ptr: 2 bits, wraps naturally.
- gnt is always one-hot or zero. sel always equals the index of the set gnt bit while busy.
- dout_valid is deasserted in IDLE (registered: low one edge after entering IDLE).

Decomposition:
- Shared package/include: N_REQ=4, SEL_W=2, state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1.
- Sub-module rr_pick4 (combinational): inputs req[3:0] and ptr[1:0]; outputs found and idx[1:0]. It is instantiated once.
- Datapath select uses one existing mux4to1 instance per data bit (generate loop over DATA_W), with i built from bit j of each requester, and its output registered into dout.

Test Plan:
1. Reset and mid-grant reset: hold rst_n=0 and check gnt=0000, sel=00, dout_valid=0, busy=0. With req=1111 during GRANT, pull rst_n low between edges and check all outputs clear immediately; after release the first grant is 0001.
2. Single short request: req=0010 for 2 cycles with din[1] = 1 then 0. Expect gnt=0010 and sel=01 from the next edge, dout = 1 then 0 with dout_valid high for exactly 2 beats, then gnt=0000. A following req=0011 grants requester 0 first because ptr=2 wraps to 0 before reaching 1.
3. Full contention: req=1111 held for 20 cycles, MAX_HOLD=4. Expect grants 0001, 0010, 0100, 1000, 0001 in 4-cycle slots, no gnt=0000 cycle, and dout_valid continuously high.
4. Wrap-around: after a grant to requester 2 ends, apply req=1001. Expect requester 3 granted first, then 0; sel goes 11 then 00.
5. Sole requester beyond hold: req=0100 for 10 cycles. Expect gnt=0100 and sel=10 constant, 10 contiguous valid beats, with hold_cnt re-arming at cycles 4 and 8 and no gap.
6. Drop with simultaneous request: requester 0 granted, req changes 0001→1000 on the same edge. Expect dout_valid=0 for that beat, gnt=1000 on the same edge (back-to-back), and ptr=1 before the scan selects 3.
